// File: rtl/arq_pkg.sv
// Shared constants for the per-link ARQ/SEQN/FLOW engine: packet TYPE codes,
// TX/RX action encodings and the data-type classifier.
// Latency: none (package). Backpressure: n/a.
package arq_pkg;

  // Payload-carrying ACL packet types; all other TYPE codes carry no ARQ'd payload
  localparam logic [3:0] PK_NULL = 4'h0;
  localparam logic [3:0] PK_DM1  = 4'h3;
  localparam logic [3:0] PK_DH1  = 4'h4;
  localparam logic [3:0] PK_DV   = 4'h8;
  localparam logic [3:0] PK_DM3  = 4'hA;
  localparam logic [3:0] PK_DH3  = 4'hB;
  localparam logic [3:0] PK_DM5  = 4'hE;
  localparam logic [3:0] PK_DH5  = 4'hF;

  localparam logic [1:0] TX_NULL = 2'd0;
  localparam logic [1:0] TX_NEW  = 2'd1;
  localparam logic [1:0] TX_OLD  = 2'd2;
  localparam logic [1:0] TX_ZERO = 2'd3;

  localparam logic [1:0] RX_NONE   = 2'd0;
  localparam logic [1:0] RX_ACCEPT = 2'd1;
  localparam logic [1:0] RX_IGNORE = 2'd2;
  localparam logic [1:0] RX_REJECT = 2'd3;

  function automatic logic is_data(input logic [3:0] pktype);
    case (pktype)
      PK_DM1, PK_DH1, PK_DV, PK_DM3, PK_DH3, PK_DM5, PK_DH5: is_data = 1'b1;
      default:                                             is_data = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arq_link_state.sv
// One logical transport's ARQ state (tseqn, seqn_old, arqn, outstanding, remote flow[, flush timer]).
// Latency: actions are combinational from current state; state commits on the enabling clock edge.
// Backpressure: none; rxbuf_full turns a new payload into REJECT. Optional timer under ARQ_FLUSH_TIMEOUT_EN.
import arq_pkg::*;

module arq_link_state
`ifdef ARQ_FLUSH_TIMEOUT_EN
#(
  parameter int FTW = 16
)
`endif
(
  input  logic           clk_6M,
  input  logic           rstz,
  input  logic           init,
  input  logic           rx_en,
  input  logic           rx_data,
  input  logic           rx_seqn,
  input  logic           rx_arqn,
  input  logic           rx_flow,
  input  logic           rx_crc_ok,
  input  logic           rxbuf_full,
  input  logic           tx_en,
  input  logic           tx_has_data,
  input  logic           flush_req,
`ifdef ARQ_FLUSH_TIMEOUT_EN
  input  logic           slot_tick,
  input  logic [FTW-1:0] flush_to,
`endif
  output logic [1:0]     rx_act,
  output logic [1:0]     tx_act,
  output logic           tx_seqn,
  output logic           arqn,
  output logic           rflow
);

  logic tseqn;
  logic seqn_old;
  logic outst;
  logic flush_eff;
  logic ack;

  // An ACK only retires something if a packet is actually outstanding
  assign ack = rx_en && outst && rx_arqn;

`ifdef ARQ_FLUSH_TIMEOUT_EN
  logic [FTW-1:0] cnt;
  logic           auto_flush;

  // Armed once the outstanding packet has aged flush_to slots; 0 means never
  assign auto_flush = outst && (flush_to != '0) && (cnt >= flush_to);
  assign flush_eff  = flush_req || auto_flush;

  // Slot age of the outstanding packet; restarts whenever a fresh payload goes out or is acked
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      cnt <= '0;
    end else if (init) begin
      cnt <= '0;
    end else if ((tx_en && ((tx_act == TX_NEW) || (tx_act == TX_ZERO))) || ack) begin
      cnt <= '0;
    end else if (outst && slot_tick && (cnt != '1)) begin
      cnt <= cnt + FTW'(1);
    end
  end
`else
  assign flush_eff = flush_req;
`endif

  // Received payload classification against the last accepted SEQN
  always_comb begin
    rx_act = RX_NONE;
    if (rx_data) begin
      if ((rx_seqn != seqn_old) && rx_crc_ok && !rxbuf_full) begin
        rx_act = RX_ACCEPT;
      end else if (rx_seqn == seqn_old) begin
        rx_act = RX_IGNORE;
      end else begin
        rx_act = RX_REJECT;
      end
    end
  end

  // TX payload selection from pre-update state
  always_comb begin
    tx_act = TX_NULL;
    if (outst && flush_eff) begin
      tx_act = TX_ZERO;
    end else if (outst) begin
      tx_act = TX_OLD;
    end else if (tx_has_data && rflow) begin
      tx_act = TX_NEW;
    end
  end

  assign tx_seqn = tseqn ^ ((tx_act == TX_NEW) || (tx_act == TX_ZERO));

  // Link state update; init wins over any concurrent RX/TX on this link
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      tseqn    <= 1'b0;
      seqn_old <= 1'b0;
      arqn     <= 1'b0;
      outst    <= 1'b0;
      rflow    <= 1'b1;
    end else if (init) begin
      tseqn    <= 1'b0;
      seqn_old <= 1'b0;
      arqn     <= 1'b0;
      outst    <= 1'b0;
      rflow    <= 1'b1;
    end else begin
      if (rx_en) begin
        rflow <= rx_flow;
        case (rx_act)
          RX_ACCEPT: begin
            arqn     <= 1'b1;
            seqn_old <= rx_seqn;
          end
          RX_IGNORE: arqn <= 1'b1;
          RX_REJECT: arqn <= 1'b0;
          default:   arqn <= arqn;
        endcase
      end
      if (tx_en && ((tx_act == TX_NEW) || (tx_act == TX_ZERO))) begin
        tseqn <= ~tseqn;
      end
      // NEW is only possible with nothing outstanding, so it never collides with an ACK
      if (tx_en && (tx_act == TX_NEW)) begin
        outst <= 1'b1;
      end else if (ack) begin
        outst <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/arq_multilink_ctrl.sv
// Multi-link ARQ/SEQN/FLOW engine: LT_ADDR decode, per-link state, registered RX/TX action outputs.
// Latency: rx_done -> rx_vld and tx_start -> tx_vld are both 1 cycle.
// Backpressure: none; remote FLOW=STOP reported on link_stop. Macro ARQ_FLUSH_TIMEOUT_EN adds slot-based auto-flush.
import arq_pkg::*;

module arq_multilink_ctrl #(
  parameter int NUM_LT = 7,
  parameter int LTW    = 3
`ifdef ARQ_FLUSH_TIMEOUT_EN
  ,
  parameter int FTW    = 16
`endif
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              conn_new,
  input  logic [LTW-1:0]    conn_lt,
  input  logic              rx_done,
  input  logic [LTW-1:0]    rx_lt,
  input  logic              rx_hec_ok,
  input  logic              rx_crc_ok,
  input  logic [3:0]        rx_pktype,
  input  logic              rx_seqn,
  input  logic              rx_arqn,
  input  logic              rx_flow,
  input  logic              rxbuf_full,
  input  logic              tx_start,
  input  logic [LTW-1:0]    tx_lt,
  input  logic              tx_has_data,
  input  logic              flush_req,
`ifdef ARQ_FLUSH_TIMEOUT_EN
  input  logic              slot_tick,
  input  logic [FTW-1:0]    flush_to,
`endif
  output logic              tx_vld,
  output logic [1:0]        tx_action,
  output logic              tx_seqn,
  output logic              tx_arqn,
  output logic              tx_flow,
  output logic              rx_vld,
  output logic [1:0]        rx_action,
  output logic [NUM_LT-1:0] link_stop
);

  logic [NUM_LT-1:0] init_hit;
  logic [NUM_LT-1:0] rx_hit;
  logic [NUM_LT-1:0] tx_hit;
  logic [NUM_LT-1:0] link_arqn;
  logic [NUM_LT-1:0] link_rflow;
  logic [NUM_LT-1:0] link_tx_seqn;
  logic [1:0]        link_rx_act [NUM_LT];
  logic [1:0]        link_tx_act [NUM_LT];
  logic              rx_data;

  logic [1:0]        rx_action_d;
  logic [1:0]        tx_action_d;
  logic              tx_seqn_d;
  logic              tx_arqn_d;

  assign rx_data = is_data(rx_pktype);

  // LT_ADDR 0 (broadcast) and out-of-range addresses match no link and so touch no state
  for (genvar i = 0; i < NUM_LT; i++) begin : g_link
    assign init_hit[i]  = conn_new && (conn_lt == LTW'(i + 1));
    assign rx_hit[i]    = rx_done && rx_hec_ok && (rx_lt == LTW'(i + 1));
    assign tx_hit[i]    = tx_start && (tx_lt == LTW'(i + 1));
    assign link_stop[i] = ~link_rflow[i];

    arq_link_state
`ifdef ARQ_FLUSH_TIMEOUT_EN
      #(.FTW(FTW))
`endif
      u_link (
      .clk_6M      (clk_6M),
      .rstz        (rstz),
      .init        (init_hit[i]),
      .rx_en       (rx_hit[i]),
      .rx_data     (rx_data),
      .rx_seqn     (rx_seqn),
      .rx_arqn     (rx_arqn),
      .rx_flow     (rx_flow),
      .rx_crc_ok   (rx_crc_ok),
      .rxbuf_full  (rxbuf_full),
      .tx_en       (tx_hit[i]),
      .tx_has_data (tx_has_data),
      .flush_req   (flush_req),
`ifdef ARQ_FLUSH_TIMEOUT_EN
      .slot_tick   (slot_tick),
      .flush_to    (flush_to),
`endif
      .rx_act      (link_rx_act[i]),
      .tx_act      (link_tx_act[i]),
      .tx_seqn     (link_tx_seqn[i]),
      .arqn        (link_arqn[i]),
      .rflow       (link_rflow[i])
    );
  end

  // Select the addressed link's RX classification; bad HEC or unknown LT gives NONE
  always_comb begin
    rx_action_d = RX_NONE;
    for (int i = 0; i < NUM_LT; i++) begin
      if (rx_hec_ok && (rx_lt == LTW'(i + 1))) begin
        rx_action_d = link_rx_act[i];
      end
    end
  end

  // Select the addressed link's TX decision; unknown LT gives NULL with zero SEQN/ARQN
  always_comb begin
    tx_action_d = TX_NULL;
    tx_seqn_d   = 1'b0;
    tx_arqn_d   = 1'b0;
    for (int i = 0; i < NUM_LT; i++) begin
      if (tx_lt == LTW'(i + 1)) begin
        tx_action_d = link_tx_act[i];
        tx_seqn_d   = link_tx_seqn[i];
        tx_arqn_d   = link_arqn[i];
      end
    end
  end

  // Output registers: one-cycle pulses, payload fields held between pulses
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      rx_vld    <= 1'b0;
      rx_action <= RX_NONE;
      tx_vld    <= 1'b0;
      tx_action <= TX_NULL;
      tx_seqn   <= 1'b0;
      tx_arqn   <= 1'b0;
      tx_flow   <= 1'b0;
    end else begin
      rx_vld <= rx_done;
      tx_vld <= tx_start;
      if (rx_done) begin
        rx_action <= rx_action_d;
      end
      if (tx_start) begin
        tx_action <= tx_action_d;
        tx_seqn   <= tx_seqn_d;
        tx_arqn   <= tx_arqn_d;
        tx_flow   <= ~rxbuf_full;
      end
    end
  end

endmodule

// File: tb/tb_arq_multilink_ctrl.sv
// Bench for arq_multilink_ctrl: vector table plus hand sequences, expected actions queued at drive time
// and compared when rx_vld/tx_vld appear. Flush-timeout sequence builds only with ARQ_FLUSH_TIMEOUT_EN.
// Clock period 10 ns; outputs sampled on the falling edge.
import arq_pkg::*;

module tb_arq_multilink_ctrl;

  logic       clk_6M = 1'b0;
  logic       rstz = 1'b0;
  logic       conn_new = 1'b0;
  logic [2:0] conn_lt = '0;
  logic       rx_done = 1'b0;
  logic [2:0] rx_lt = '0;
  logic       rx_hec_ok = 1'b0;
  logic       rx_crc_ok = 1'b0;
  logic [3:0] rx_pktype = '0;
  logic       rx_seqn = 1'b0;
  logic       rx_arqn = 1'b0;
  logic       rx_flow = 1'b0;
  logic       rxbuf_full = 1'b0;
  logic       tx_start = 1'b0;
  logic [2:0] tx_lt = '0;
  logic       tx_has_data = 1'b0;
  logic       flush_req = 1'b0;
`ifdef ARQ_FLUSH_TIMEOUT_EN
  logic        slot_tick = 1'b0;
  logic [15:0] flush_to = 16'd3;
`endif
  logic       tx_vld;
  logic [1:0] tx_action;
  logic       tx_seqn;
  logic       tx_arqn;
  logic       tx_flow;
  logic       rx_vld;
  logic [1:0] rx_action;
  logic [6:0] link_stop;

  int nerr = 0;
  int nchk = 0;

  logic [1:0] rx_q [$];
  logic [4:0] tx_q [$];   // {action, seqn, arqn, flow}

  always #5 clk_6M = ~clk_6M;

  arq_multilink_ctrl dut (
    .clk_6M      (clk_6M),
    .rstz        (rstz),
    .conn_new    (conn_new),
    .conn_lt     (conn_lt),
    .rx_done     (rx_done),
    .rx_lt       (rx_lt),
    .rx_hec_ok   (rx_hec_ok),
    .rx_crc_ok   (rx_crc_ok),
    .rx_pktype   (rx_pktype),
    .rx_seqn     (rx_seqn),
    .rx_arqn     (rx_arqn),
    .rx_flow     (rx_flow),
    .rxbuf_full  (rxbuf_full),
    .tx_start    (tx_start),
    .tx_lt       (tx_lt),
    .tx_has_data (tx_has_data),
    .flush_req   (flush_req),
`ifdef ARQ_FLUSH_TIMEOUT_EN
    .slot_tick   (slot_tick),
    .flush_to    (flush_to),
`endif
    .tx_vld      (tx_vld),
    .tx_action   (tx_action),
    .tx_seqn     (tx_seqn),
    .tx_arqn     (tx_arqn),
    .tx_flow     (tx_flow),
    .rx_vld      (rx_vld),
    .rx_action   (rx_action),
    .link_stop   (link_stop)
  );

  typedef struct {
    logic       cn, rx, tx;
    logic [2:0] lt;
    logic [3:0] pk;
    logic       seqn, arqn, flow, hec, crc, full, data, flush;
    logic [1:0] e_rx, e_tx;
    logic       e_seqn, e_arqn;
    logic [6:0] e_stop;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t vz(input logic [2:0] lt, input logic [6:0] stop);
    vec_t v;
    v = '{cn:0, rx:0, tx:0, lt:lt, pk:PK_NULL, seqn:0, arqn:0, flow:1, hec:1, crc:1, full:0,
          data:0, flush:0, e_rx:RX_NONE, e_tx:TX_NULL, e_seqn:0, e_arqn:0, e_stop:stop};
    return v;
  endfunction

  function automatic vec_t vcn(input logic [2:0] lt, input logic [6:0] stop);
    vec_t v;
    v = vz(lt, stop);
    v.cn = 1'b1;
    return v;
  endfunction

  function automatic vec_t vrx(input logic [2:0] lt, input logic [3:0] pk, input logic seqn, input logic arqn,
                               input logic flow, input logic hec, input logic crc, input logic full,
                               input logic [1:0] e_rx, input logic [6:0] stop);
    vec_t v;
    v = vz(lt, stop);
    v.rx = 1'b1; v.pk = pk; v.seqn = seqn; v.arqn = arqn; v.flow = flow;
    v.hec = hec; v.crc = crc; v.full = full; v.e_rx = e_rx;
    return v;
  endfunction

  function automatic vec_t vtx(input logic [2:0] lt, input logic data, input logic flush, input logic full,
                               input logic [1:0] e_tx, input logic e_seqn, input logic e_arqn,
                               input logic [6:0] stop);
    vec_t v;
    v = vz(lt, stop);
    v.tx = 1'b1; v.data = data; v.flush = flush; v.full = full;
    v.e_tx = e_tx; v.e_seqn = e_seqn; v.e_arqn = e_arqn;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(posedge clk_6M); #1;
    conn_new = v.cn;  conn_lt = v.lt;
    rx_done = v.rx;   rx_lt = v.lt; rx_pktype = v.pk; rx_seqn = v.seqn; rx_arqn = v.arqn;
    rx_flow = v.flow; rx_hec_ok = v.hec; rx_crc_ok = v.crc; rxbuf_full = v.full;
    tx_start = v.tx;  tx_lt = v.lt; tx_has_data = v.data; flush_req = v.flush;
    if (v.rx) rx_q.push_back(v.e_rx);
    if (v.tx) tx_q.push_back({v.e_tx, v.e_seqn, v.e_arqn, ~v.full});
    @(posedge clk_6M); #1;
    conn_new = 1'b0; rx_done = 1'b0; tx_start = 1'b0; flush_req = 1'b0; rxbuf_full = 1'b0;
    @(negedge clk_6M);
    chk("link_stop", 32'(link_stop), 32'(v.e_stop));
  endtask

`ifdef ARQ_FLUSH_TIMEOUT_EN
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_6M); #1 slot_tick = 1'b1;
      @(posedge clk_6M); #1 slot_tick = 1'b0;
    end
  endtask
`endif

  // Scoreboard: pop the queued expectation whenever the DUT reports an action
  always @(negedge clk_6M) begin
    if (rx_vld) begin
      if (rx_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL rx_unexpected: rx_vld with action %0d, none expected", rx_action);
      end else begin
        chk("rx_action", 32'(rx_action), 32'(rx_q.pop_front()));
      end
    end
    if (tx_vld) begin
      if (tx_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL tx_unexpected: tx_vld with action %0d, none expected", tx_action);
      end else begin
        chk("tx_act_seqn_arqn_flow", 32'({tx_action, tx_seqn, tx_arqn, tx_flow}), 32'(tx_q.pop_front()));
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt [$];
  localparam logic [6:0] S4 = 7'b0001000;

  initial begin
    // Test 1: NEW then ack via NULL, NEW with toggled SEQN
    vt.push_back(vcn(2, 0));
    vt.push_back(vtx(2, 1, 0, 0, TX_NEW, 1, 0, 0));
    vt.push_back(vrx(2, PK_NULL, 0, 1, 1, 1, 1, 0, RX_NONE, 0));
    vt.push_back(vtx(2, 1, 0, 0, TX_NEW, 0, 0, 0));
    // Test 2: ACCEPT / IGNORE / REJECT and the ARQN carried back
    vt.push_back(vrx(1, PK_DH1, 1, 0, 1, 1, 1, 0, RX_ACCEPT, 0));
    vt.push_back(vtx(1, 0, 0, 0, TX_NULL, 0, 1, 0));
    vt.push_back(vrx(1, PK_DH1, 1, 0, 1, 1, 1, 0, RX_IGNORE, 0));
    vt.push_back(vtx(1, 0, 0, 0, TX_NULL, 0, 1, 0));
    vt.push_back(vrx(1, PK_DH1, 0, 0, 1, 1, 0, 0, RX_REJECT, 0));
    vt.push_back(vtx(1, 0, 0, 0, TX_NULL, 0, 0, 0));
    // Test 3: NACK -> OLD, flush -> ZERO with toggle, then OLD of the zero-length packet
    vt.push_back(vtx(3, 1, 0, 0, TX_NEW, 1, 0, 0));
    vt.push_back(vrx(3, PK_NULL, 0, 0, 1, 1, 1, 0, RX_NONE, 0));
    vt.push_back(vtx(3, 1, 0, 0, TX_OLD, 1, 0, 0));
    vt.push_back(vtx(3, 1, 1, 0, TX_ZERO, 0, 0, 0));
    vt.push_back(vtx(3, 1, 0, 0, TX_OLD, 0, 0, 0));
    // Test 4: remote STOP blocks NEW, GO releases it
    vt.push_back(vrx(4, PK_NULL, 0, 0, 0, 1, 1, 0, RX_NONE, S4));
    vt.push_back(vtx(4, 1, 0, 0, TX_NULL, 0, 0, S4));
    vt.push_back(vrx(4, PK_NULL, 0, 0, 1, 1, 1, 0, RX_NONE, 0));
    vt.push_back(vtx(4, 1, 0, 0, TX_NEW, 1, 0, 0));
    // Test 5 (first part): NEW outstanding on lt 5
    vt.push_back(vtx(5, 1, 0, 0, TX_NEW, 1, 0, 0));
    // Broadcast address: no action, no state change (flow=0 must not stop anything)
    vt.push_back(vrx(0, PK_DH1, 1, 1, 0, 1, 1, 0, RX_NONE, 0));
    vt.push_back(vtx(0, 1, 0, 0, TX_NULL, 0, 0, 0));
    // Bad HEC: no state change (seqn=1 would otherwise be IGNORE and set ARQN)
    vt.push_back(vrx(1, PK_DH1, 1, 0, 0, 0, 1, 0, RX_NONE, 0));
    vt.push_back(vtx(1, 0, 0, 0, TX_NULL, 0, 0, 0));

    rstz = 1'b0;
    repeat (3) @(posedge clk_6M);
    #1 rstz = 1'b1;
    @(negedge clk_6M);
    chk("reset_outputs", 32'({rx_vld, rx_action, tx_vld, tx_action, tx_seqn, tx_arqn, tx_flow, link_stop}), 32'd0);

    for (int i = 0; i < vt.size(); i++) apply(vt[i]);

    // Test 5: RX ack and TX start together on lt 5 -> OLD now, NEW next
    begin
      vec_t v;
      v = vtx(5, 1, 0, 0, TX_OLD, 1, 0, 0);
      v.rx = 1'b1; v.pk = PK_NULL; v.arqn = 1'b1; v.e_rx = RX_NONE;
      apply(v);
    end
    apply(vtx(5, 1, 0, 0, TX_NEW, 0, 0, 0));
    apply(vrx(5, PK_DM1, 1, 0, 1, 1, 1, 1, RX_REJECT, 0));
    apply(vtx(5, 1, 0, 1, TX_OLD, 0, 0, 0));

    // conn_new re-initialises an outstanding link: NEW with SEQN=1 instead of OLD
    apply(vcn(3, 0));
    apply(vtx(3, 1, 0, 0, TX_NEW, 1, 0, 0));

`ifdef ARQ_FLUSH_TIMEOUT_EN
    // Test 6: auto-flush after flush_to slots, not before; flush_to=0 disables
    flush_to = 16'd3;
    apply(vtx(6, 1, 0, 0, TX_NEW, 1, 0, 0));
    ticks(3);
    apply(vtx(6, 1, 0, 0, TX_ZERO, 0, 0, 0));
    ticks(2);
    apply(vtx(6, 1, 0, 0, TX_OLD, 0, 0, 0));
    ticks(1);
    apply(vtx(6, 1, 0, 0, TX_ZERO, 1, 0, 0));
    flush_to = 16'd0;
    ticks(5);
    apply(vtx(6, 1, 0, 0, TX_OLD, 1, 0, 0));
`endif

    // Reset mid-operation: pending tx_start dropped, every link cleared
    apply(vrx(4, PK_NULL, 0, 0, 0, 1, 1, 0, RX_NONE, S4));
    @(posedge clk_6M); #1;
    tx_start = 1'b1; tx_lt = 3'd5; tx_has_data = 1'b1;
    #2 rstz = 1'b0;
    @(posedge clk_6M); #1 tx_start = 1'b0;
    repeat (2) @(posedge clk_6M);
    #1 rstz = 1'b1;
    @(negedge clk_6M);
    chk("reset_mid_outputs", 32'({rx_vld, tx_vld, tx_action, tx_seqn, link_stop}), 32'd0);
    apply(vtx(5, 1, 0, 0, TX_NEW, 1, 0, 0));

    // Drain with a bound; anything left over is a missing DUT response
    for (int k = 0; k < 50 && (rx_q.size() != 0 || tx_q.size() != 0); k++) @(posedge clk_6M);
    repeat (2) @(posedge clk_6M);
    chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
